aes_key_stream: RTL and testbench

Parametrised AES key-schedule engine for the encryption datapath. It holds NUM_SLOTS stored cipher keys, each tagged 128, 192 or 256-bit. On a start request it streams every round key of the selected slot, in order, to the cipher round logic over a valid/ready handshake. It replaces the fixed two-key, 256-bit-only key evolver and adds multi-slot storage, all three FIPS-197 key lengths, and backpressure.

---
 rtl/aes_key_stream.sv | 182 ++++++++++++++++++
 tb/tb_aes_key_stream.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_stream.sv
// AES key-schedule engine: multi-slot key store that streams FIPS-197 round keys
// (128/192/256-bit keys) over a valid/ready handshake, one schedule word per cycle.

module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;

    always_comb begin
        // Inverse as a^254 = (a^127)^2, built by repeated square-and-multiply; 0 maps to 0.
        inv = a_i;
        for (int k = 0; k < 6; k++) inv = gf_mul(gf_mul(inv, inv), a_i);
        inv = gf_mul(inv, inv);
        s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_stream #(
    parameter int NUM_SLOTS = 2,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_wr_en,
    input  logic [SLOT_W-1:0] key_wr_slot,
    input  logic [1:0]        key_wr_len,
    input  logic [255:0]      key_wr_data,
    input  logic              start,
    input  logic [SLOT_W-1:0] start_slot,
    output logic              busy,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [127:0]      rk_data,
    output logic [3:0]        rk_round,
    output logic              rk_last,
    output logic [3:0]        rk_nr
);
    typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_e;

    state_e       state_q, state_d;
    logic [255:0] slot_key_q [NUM_SLOTS];
    logic [1:0]   slot_len_q [NUM_SLOTS];
    logic [31:0]  win_q [8];
    logic [31:0]  asm_q [3];
    logic [5:0]   idx_q;
    logic [2:0]   phase_q;
    logic [7:0]   rcon_q;
    logic [3:0]   nk_q, nr_q;
    logic         valid_q, last_q;
    logic [127:0] data_q;
    logic [3:0]   round_q;

    logic         start_ok, advance, xfer, key_phase, last_word;
    logic [3:0]   nk_sel;
    logic [5:0]   last_idx;
    logic [31:0]  prev_w, back_w, sub_in, sub_out, t_w, new_w;

    assign start_ok  = (state_q == IDLE) && start;
    assign key_phase = idx_q < {2'b00, nk_q};
    assign last_idx  = {nr_q, 2'b11};
    assign last_word = (idx_q == last_idx);
    // The 4th word of a round key may only be produced if the output register can take it.
    assign advance   = (state_q == GEN) && !((idx_q[1:0] == 2'b11) && valid_q && !rk_ready);
    assign xfer      = advance && (idx_q[1:0] == 2'b11);
    assign prev_w    = win_q[7];
    assign sub_in    = (phase_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.a_i(sub_in[8*b +: 8]), .s_o(sub_out[8*b +: 8]));
    end

    always_comb begin
        case (nk_q)
            4'd6:    back_w = win_q[2];
            4'd8:    back_w = win_q[0];
            default: back_w = win_q[4];
        endcase
        t_w = prev_w;
        if (phase_q == 3'd0)                        t_w = sub_out ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && phase_q == 3'd4)   t_w = sub_out;
        // During the key phase the window rotates, leaving w[i-1] and w[i-Nk] in place afterwards.
        new_w = key_phase ? win_q[0] : (back_w ^ t_w);
    end

    always_comb begin
        case (slot_len_q[start_slot])
            2'b01:   nk_sel = 4'd6;
            2'b10:   nk_sel = 4'd8;
            default: nk_sel = 4'd4;
        endcase
    end

    always_comb begin
        // NOTE: assigning the default first means every path drives state_d, so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = GEN;
            GEN:     if (xfer && last_word) state_d = DRAIN;
            DRAIN:   if (valid_q && rk_ready && last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            // NOTE: key storage is reset on purpose: a zero 128-bit key is the defined slot default.
            for (int s = 0; s < NUM_SLOTS; s++) begin
                slot_key_q[s] <= '0;
                slot_len_q[s] <= '0;
            end
            for (int j = 0; j < 8; j++) win_q[j] <= '0;
            for (int j = 0; j < 3; j++) asm_q[j] <= '0;
            idx_q   <= '0;
            phase_q <= '0;
            rcon_q  <= '0;
            nk_q    <= '0;
            nr_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            round_q <= '0;
        end else begin
            // NOTE: non-blocking updates let a same-edge start snapshot the slot value before this write.
            state_q <= state_d;
            if (key_wr_en) begin
                slot_key_q[key_wr_slot] <= key_wr_data;
                slot_len_q[key_wr_slot] <= key_wr_len;
            end
            if (start_ok) begin
                for (int j = 0; j < 8; j++) win_q[j] <= slot_key_q[start_slot][255-32*j -: 32];
                idx_q   <= '0;
                phase_q <= '0;
                rcon_q  <= 8'h01;
                nk_q    <= nk_sel;
                nr_q    <= nk_sel + 4'd6;
            end else if (advance) begin
                for (int j = 0; j < 7; j++) win_q[j] <= win_q[j+1];
                win_q[7] <= new_w;
                idx_q    <= idx_q + 6'd1;
                phase_q  <= ({1'b0, phase_q} == nk_q - 4'd1) ? 3'd0 : phase_q + 3'd1;
                if (phase_q == 3'd0 && !key_phase)
                    rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                case (idx_q[1:0])
                    2'b00:   asm_q[0] <= new_w;
                    2'b01:   asm_q[1] <= new_w;
                    2'b10:   asm_q[2] <= new_w;
                    default: ;
                endcase
            end
            if (xfer) begin
                valid_q <= 1'b1;
                data_q  <= {asm_q[0], asm_q[1], asm_q[2], new_w};
                round_q <= idx_q[5:2];
                last_q  <= last_word;
            end else if (valid_q && rk_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign rk_valid = valid_q;
    assign rk_data  = data_q;
    assign rk_round = round_q;
    assign rk_last  = last_q;
    assign rk_nr    = nr_q;
endmodule

// File: tb/tb_aes_key_stream.sv
// Bench for aes_key_stream: a FIPS-197 key-expansion model feeds a scoreboard queue,
// and a negedge monitor checks every handshake plus stability of stalled keys.

module tb_aes_key_stream;
    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   round;
        logic         last;
        logic [3:0]   nr;
    } rk_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_wr_en;
    logic [0:0]   key_wr_slot;
    logic [1:0]   key_wr_len;
    logic [255:0] key_wr_data;
    logic         start;
    logic [0:0]   start_slot;
    logic         busy, rk_valid, rk_ready, rk_last;
    logic [127:0] rk_data;
    logic [3:0]   rk_round, rk_nr;

    aes_key_stream #(.NUM_SLOTS(2)) dut (
        .clk(clk), .rst(rst),
        .key_wr_en(key_wr_en), .key_wr_slot(key_wr_slot), .key_wr_len(key_wr_len),
        .key_wr_data(key_wr_data), .start(start), .start_slot(start_slot),
        .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
        .rk_round(rk_round), .rk_last(rk_last), .rk_nr(rk_nr)
    );

    always #5 clk = ~clk;

    int           cyc = 0;
    int           n_checks = 0;
    int           n_err = 0;
    int           hs_cnt = 0;
    int           first_hs = 0;
    int           last_hs = 0;
    bit           ready_rand = 1'b0;
    rk_t          exp_q[$];
    rk_t          mon_e;
    logic [127:0] obs [16];
    logic [7:0]   sbox_tab [256];
    logic [31:0]  ref_w [60];
    int           ref_nr;
    logic [255:0] model_key [2];
    logic [1:0]   model_len [2];
    bit           held = 1'b0;
    logic [127:0] held_data;
    logic [3:0]   held_round;
    logic         held_last;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8];
            sbox_tab[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input logic [1:0] len);
        int nk;
        logic [7:0]  rc;
        logic [31:0] t;
        nk = (len == 2'b01) ? 6 : (len == 2'b10) ? 8 : 4;
        ref_nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4 * (ref_nr + 1); i++) begin
            if (i < nk) begin
                ref_w[i] = key[255-32*i -: 32];
            end else begin
                t = ref_w[i-1];
                if (i % nk == 0) begin
                    t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk == 8 && i % 8 == 4) begin
                    t = subword(t);
                end
                ref_w[i] = ref_w[i-nk] ^ t;
            end
        end
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        key_wr_en = 1'b0;
        start     = 1'b0;
        rk_ready  = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic write_key(input int slot, input logic [1:0] len, input logic [255:0] key);
        key_wr_en   = 1'b1;
        key_wr_slot = 1'(slot);
        key_wr_len  = len;
        key_wr_data = key;
        step();
        model_key[slot] = key;
        model_len[slot] = len;
    endtask

    task automatic start_run(input int slot, output int e0);
        rk_t e;
        expand(model_key[slot], model_len[slot]);
        for (int r = 0; r <= ref_nr; r++) begin
            e.data  = {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
            e.round = 4'(r);
            e.last  = (r == ref_nr);
            e.nr    = 4'(ref_nr);
            exp_q.push_back(e);
        end
        for (int r = 0; r < 16; r++) obs[r] = '0;
        hs_cnt     = 0;
        start      = 1'b1;
        start_slot = 1'(slot);
        step();
        e0 = cyc;
    endtask

    task automatic wait_done(input int e0, input int exp_first, input int exp_last);
        int n;
        n = 0;
        while (!(hs_cnt == ref_nr + 1 && !busy) && n < 3000) begin
            step();
            n++;
        end
        check("run_in_budget", n < 3000, 1'b1);
        check("handshake_count", hs_cnt, ref_nr + 1);
        check("queue_empty", exp_q.size(), 0);
        if (exp_first >= 0) check("first_key_edge", first_hs - e0, exp_first);
        if (exp_last >= 0)  check("last_key_edge", last_hs - e0, exp_last);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_data", rk_data, held_data);
                check("hold_tag", {rk_valid, rk_round, rk_last}, {1'b1, held_round, held_last});
            end
            if (rk_valid && rk_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_key", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rk_data", rk_data, mon_e.data);
                    check("rk_tag", {rk_round, rk_last, rk_nr}, {mon_e.round, mon_e.last, mon_e.nr});
                end
                obs[rk_round] = rk_data;
                if (hs_cnt == 0) first_hs = cyc;
                last_hs = cyc;
                hs_cnt++;
                held = 1'b0;
            end else if (rk_valid) begin
                held       = 1'b1;
                held_data  = rk_data;
                held_round = rk_round;
                held_last  = rk_last;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int s;
        int n;
        logic [255:0] new_key;
        build_sbox();
        rst = 1'b1; key_wr_en = 1'b0; key_wr_slot = '0; key_wr_len = '0; key_wr_data = '0;
        start = 1'b0; start_slot = '0; rk_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin model_key[k] = '0; model_len[k] = '0; end
        repeat (3) step();
        check("reset_busy", busy, 1'b0);
        check("reset_valid", rk_valid, 1'b0);
        check("reset_data", rk_data, '0);
        check("reset_round", rk_round, 4'd0);
        check("reset_last", rk_last, 1'b0);
        check("reset_nr", rk_nr, 4'd0);
        rst = 1'b0;

        write_key(0, 2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        start_run(0, e0);
        wait_done(e0, 4, 44);
        check("aes128_round1", obs[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("aes128_round10", obs[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        write_key(0, 2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
        start_run(0, e0);
        wait_done(e0, 4, 52);
        check("aes192_round12", obs[12], 128'he98ba06f448c773c8ecc720401002202);

        write_key(1, 2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        start_run(1, e0);
        wait_done(e0, 4, 60);
        check("aes256_round14", obs[14], 128'hfe4890d1e6188d0b046df344706c631e);

        ready_rand = 1'b1;
        start_run(1, e0);
        wait_done(e0, -1, -1);
        check("aes256_bp_round14", obs[14], 128'hfe4890d1e6188d0b046df344706c631e);

        // Mid-run: a second start must be ignored and a rewrite of the running slot must not leak in.
        start_run(1, e0);
        repeat (12) step();
        start = 1'b1;
        start_slot = 1'b0;
        step();
        write_key(1, 2'b00, rand256());
        wait_done(e0, -1, -1);
        start_run(1, e0);
        wait_done(e0, -1, -1);

        for (int k = 0; k < 4; k++) begin
            s = int'($urandom_range(0, 1));
            write_key(s, 2'($urandom_range(0, 3)), rand256());
            start_run(s, e0);
            wait_done(e0, -1, -1);
        end

        new_key = rand256();
        key_wr_en   = 1'b1;
        key_wr_slot = 1'b0;
        key_wr_len  = 2'b10;
        key_wr_data = new_key;
        start_run(0, e0);
        model_key[0] = new_key;
        model_len[0] = 2'b10;
        wait_done(e0, -1, -1);
        start_run(0, e0);
        wait_done(e0, -1, -1);

        ready_rand = 1'b0;
        start_run(1, e0);
        n = 0;
        while (hs_cnt < 5 && n < 500) begin
            step();
            n++;
        end
        check("reached_round5", hs_cnt, 5);
        exp_q.delete();
        rst = 1'b1;
        step();
        check("midreset_busy", busy, 1'b0);
        check("midreset_valid", rk_valid, 1'b0);
        check("midreset_data", rk_data, '0);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin model_key[k] = '0; model_len[k] = '0; end
        start_run(0, e0);
        wait_done(e0, 4, 44);
        check("zero_key_slot0_round1", obs[1], 128'h62636363626363636263636362636363);
        start_run(1, e0);
        wait_done(e0, 4, 44);
        check("zero_key_slot1_round1", obs[1], 128'h62636363626363636263636362636363);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
